// File: rtl/branch_resolve_seq_pkg.sv
// rtl/branch_resolve_seq_pkg.sv - shared slot encoding and sizing for the branch resolve sequencer
package branch_resolve_seq_pkg;

  // Sized to match the predictor's update queue so tags never outnumber its entries.
  localparam int PRED_UPD_QUEUE_DEPTH = 8;
  localparam int BRSEQ_DEPTH          = PRED_UPD_QUEUE_DEPTH;
  localparam int BRSEQ_DEPTH_W        = $clog2(BRSEQ_DEPTH);

  localparam int CDB_TAKEN_BIT = 0;

  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'b00,
    SLOT_PENDING  = 2'b01,
    SLOT_RESOLVED = 2'b10
  } slot_state_e;

endpackage

// File: rtl/branch_resolve_slot.sv
// rtl/branch_resolve_slot.sv - one in-flight branch slot: state, pc and resolved direction
module branch_resolve_slot
  import branch_resolve_seq_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        alloc_en,
  input  logic [31:0] alloc_pc,
  input  logic        resolve_en,
  input  logic        resolve_taken,
  input  logic        clear_en,
  output slot_state_e state,
  output logic [31:0] pc,
  output logic        taken
);

  slot_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        taken_q, taken_d;

  // Clear outranks everything so a bypassed pop never leaves the slot RESOLVED.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    if (clear_en) begin
      state_d = SLOT_EMPTY;
    end else if (alloc_en) begin
      state_d = SLOT_PENDING;
      pc_d    = alloc_pc;
      taken_d = 1'b0;
    end else if (resolve_en && state_q == SLOT_PENDING) begin
      state_d = SLOT_RESOLVED;
      taken_d = resolve_taken;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= SLOT_EMPTY;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  assign state = state_q;
  assign pc    = pc_q;
  assign taken = taken_q;

endmodule

// File: rtl/branch_resolve_seq.sv
// rtl/branch_resolve_seq.sv - in-order replay of out-of-order branch resolutions to the predictor
// BRSEQ_BYPASS_EN: forward a CDB result targeting a pending head straight to the update port.
module branch_resolve_seq
  import branch_resolve_seq_pkg::*;
#(
  parameter int DEPTH   = BRSEQ_DEPTH,
  parameter int DEPTH_W = BRSEQ_DEPTH_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               alloc_valid,
  input  logic [31:0]        alloc_pc,
  output logic               alloc_ready,
  output logic [DEPTH_W-1:0] alloc_tag,
  input  logic               cdb_active,
  input  logic               cdb_is_br,
  input  logic [DEPTH_W-1:0] cdb_tag,
  input  logic [31:0]        cdb_val,
  output logic               upd_valid,
  output logic [31:0]        upd_pc,
  output logic               upd_taken,
  input  logic               upd_ready,
  input  logic               flush_in,
  output logic [DEPTH_W:0]   count
);

  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_W:0]   count_q, count_d;

  slot_state_e      slot_state [DEPTH];
  logic [31:0]      slot_pc    [DEPTH];
  logic             slot_taken [DEPTH];
  logic [DEPTH-1:0] slot_alloc, slot_resolve, slot_clear;

  logic cdb_hit, do_alloc, do_pop, do_flush;
  logic head_busy, head_resolved, bypass_hit;
  logic unused_cdb_bits;

  assign unused_cdb_bits = ^cdb_val[31:1];

  assign alloc_ready = (count_q != CNT_FULL);
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  always_comb begin
    cdb_hit       = rdy_in && cdb_active && cdb_is_br;
    do_flush      = rdy_in && flush_in;
    head_busy     = (slot_state[head_q] != SLOT_EMPTY);
    head_resolved = (slot_state[head_q] == SLOT_RESOLVED);
`ifdef BRSEQ_BYPASS_EN
    bypass_hit = cdb_hit && (cdb_tag == head_q) && (slot_state[head_q] == SLOT_PENDING);
`else
    bypass_hit = 1'b0;
`endif
    upd_valid = rdy_in && (head_resolved || bypass_hit);
    upd_pc    = upd_valid ? slot_pc[head_q] : '0;
    upd_taken = upd_valid && (head_resolved ? slot_taken[head_q] : cdb_val[CDB_TAKEN_BIT]);
    do_pop    = upd_valid && upd_ready;
    // alloc_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    do_alloc  = rdy_in && alloc_valid && alloc_ready && !flush_in;
  end

  always_comb begin
    slot_alloc   = '0;
    slot_resolve = '0;
    slot_clear   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_alloc[i]   = do_alloc && (tail_q == DEPTH_W'(i));
      // During a flush only the surviving head may still take its result.
      slot_resolve[i] = cdb_hit && (cdb_tag == DEPTH_W'(i)) &&
                        (!do_flush || (head_q == DEPTH_W'(i)));
      slot_clear[i]   = (do_pop && (head_q == DEPTH_W'(i))) ||
                        (do_flush && (head_q != DEPTH_W'(i)));
    end
  end

  always_comb begin
    head_d  = do_pop ? head_q + PTR_ONE : head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_flush) begin
      tail_d  = head_busy ? head_q + PTR_ONE : head_q;
      count_d = (head_busy && !do_pop) ? CNT_ONE : '0;
    end else begin
      if (do_alloc) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (do_alloc && !do_pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!do_alloc && do_pop) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    branch_resolve_slot u_slot (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .alloc_en      (slot_alloc[g]),
      .alloc_pc      (alloc_pc),
      .resolve_en    (slot_resolve[g]),
      .resolve_taken (cdb_val[CDB_TAKEN_BIT]),
      .clear_en      (slot_clear[g]),
      .state         (slot_state[g]),
      .pc            (slot_pc[g]),
      .taken         (slot_taken[g])
    );
  end

endmodule

// File: tb/tb_branch_resolve_seq.sv
// tb/tb_branch_resolve_seq.sv - vector table plus scoreboard bench for branch_resolve_seq
module tb_branch_resolve_seq;

`ifdef BRSEQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [31:0] alloc_pc = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_active = 1'b0;
  logic        cdb_is_br = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready = 1'b0;
  logic        flush_in = 1'b0;
  logic [3:0]  count;

  branch_resolve_seq #(.DEPTH(8), .DEPTH_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_active(cdb_active), .cdb_is_br(cdb_is_br), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .flush_in(flush_in), .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic rst; logic rdy; logic av; logic [31:0] apc; logic sbt;
    logic ca; logic cib; logic [2:0] ct; logic [31:0] cv; logic ur;
    logic e_ar; logic [2:0] e_tag; logic [3:0] e_cnt; logic e_uv; logic [31:0] e_pc; logic e_ut;
  } vec_t;

  typedef struct packed { logic taken; logic [31:0] pc; } exp_t;

  vec_t        tbl[$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mpc [8];
  logic [31:0] pc;
  int          mh, nt;

  function automatic vec_t mk(input logic rst, rdy, av, input logic [31:0] apc, input logic sbt,
                              input logic ca, cib, input logic [2:0] ct, input logic [31:0] cv,
                              input logic ur, e_ar, input logic [2:0] e_tag, input logic [3:0] e_cnt,
                              input logic e_uv, input logic [31:0] e_pc, input logic e_ut);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.av = av; v.apc = apc; v.sbt = sbt;
    v.ca = ca; v.cib = cib; v.ct = ct; v.cv = cv; v.ur = ur;
    v.e_ar = e_ar; v.e_tag = e_tag; v.e_cnt = e_cnt; v.e_uv = e_uv; v.e_pc = e_pc; v.e_ut = e_ut;
    return v;
  endfunction

  function automatic logic tk(input logic [31:0] p);
    return p[2] ^ p[4];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic av, input logic [31:0] apc, input logic ca,
                     input logic cib, input logic [2:0] ct, input logic [31:0] cv,
                     input logic ur, input logic fl);
    rdy_in = r; alloc_valid = av; alloc_pc = apc; cdb_active = ca; cdb_is_br = cib;
    cdb_tag = ct; cdb_val = cv; upd_ready = ur; flush_in = fl;
    #2;
  endtask

  task automatic idle(input logic ur);
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, ur, 1'b0);
  endtask

  task automatic resolve(input logic [2:0] t, input logic v, input logic ur);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, t, 32'(v), ur, 1'b0);
  endtask

  task automatic alloc(input logic [31:0] p);
    drv(1'b1, 1'b1, p, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor the handshake, keep the expected queue aligned with flushes, then advance a cycle.
  task automatic fin(input logic push, input logic sbt);
    logic popped;
    exp_t e;
    popped = 1'b0;
    if (upd_valid && upd_ready) begin
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got update pc %0h want none", upd_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", upd_pc, e.pc);
        chk("sb_taken", 32'(upd_taken), 32'(e.taken));
      end
    end
    if (rdy_in && flush_in) begin
      if (popped) exp_q.delete();
      else while (exp_q.size() > 1) void'(exp_q.pop_back());
    end
    if (push) begin
      e.taken = sbt; e.pc = alloc_pc;
      exp_q.push_back(e);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0; cdb_active = 1'b0; flush_in = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_tag", 32'(alloc_tag), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_upd_taken", 32'(upd_taken), 0);
    exp_q.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  initial begin
    // rst rdy av apc sbt | ca cib ct cv ur | ar tag cnt uv pc ut
    tbl.push_back(mk(1,1,1,32'h100,1, 0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h104,0, 0,0,0,0,0, 1,1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0,1,0, 1,2,2,BYP,BYP ? 32'h100 : 32'h0,BYP));
    tbl.push_back(mk(0,1,0,0,0, 1,1,1,0,1, 1,2,2,1,32'h100,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,2,1,1,32'h104,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,2,0,0,0,0));
    tbl.push_back(mk(1,1,1,32'h200,1, 0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h204,0, 0,0,0,0,0, 1,1,1,0,0,0));
    tbl.push_back(mk(0,1,1,32'h208,1, 0,0,0,0,0, 1,2,2,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,2,1,0, 1,3,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,1,0,0, 1,3,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,0,1,1, 1,3,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,3,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0,1,0, 1,3,3,BYP,BYP ? 32'h200 : 32'h0,BYP));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,3,3,1,32'h200,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,3,2,1,32'h204,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,3,1,1,32'h208,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,3,0,0,0,0));
    tbl.push_back(mk(0,0,1,32'h300,0, 0,0,0,0,0, 1,3,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h300,0, 0,0,0,0,0, 1,3,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,3,1,1, 1,4,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,4,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,3,0,0, 1,4,1,BYP,BYP ? 32'h300 : 32'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 1,4,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,4,1,1,32'h300,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,4,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,4,1,1, 1,4,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h400,1, 0,0,0,0,1, 1,4,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,1, 1,5,1,0,0,0));

    #1;
    foreach (tbl[n]) begin
      if (tbl[n].rst) do_reset();
      drv(tbl[n].rdy, tbl[n].av, tbl[n].apc, tbl[n].ca, tbl[n].cib, tbl[n].ct, tbl[n].cv,
          tbl[n].ur, 1'b0);
      chk($sformatf("v%0d_alloc_ready", n), 32'(alloc_ready), 32'(tbl[n].e_ar));
      chk($sformatf("v%0d_alloc_tag", n), 32'(alloc_tag), 32'(tbl[n].e_tag));
      chk($sformatf("v%0d_count", n), 32'(count), 32'(tbl[n].e_cnt));
      chk($sformatf("v%0d_upd_valid", n), 32'(upd_valid), 32'(tbl[n].e_uv));
      chk($sformatf("v%0d_upd_pc", n), upd_pc, tbl[n].e_pc);
      chk($sformatf("v%0d_upd_taken", n), 32'(upd_taken), 32'(tbl[n].e_ut));
      fin(tbl[n].rdy && tbl[n].av && tbl[n].e_ar, tbl[n].sbt);
    end

    // Fill to capacity, check the conservative full flag, then wrap tags through 20 pairs.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc = 32'h500 + 32'(4 * i);
      alloc(pc);
      chk("full_tag", 32'(alloc_tag), 32'(i));
      fin(1'b1, tk(pc));
      mpc[i] = pc;
    end
    drv(1'b1, 1'b1, 32'h5f0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_count", 32'(count), 8);
    fin(1'b0, 1'b0);
    resolve(3'd0, tk(mpc[0]), 1'b0);
    fin(1'b0, 1'b0);
    drv(1'b1, 1'b1, 32'h5f4, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    chk("full_pop_ready", 32'(alloc_ready), 0);
    chk("full_pop_uv", 32'(upd_valid), 1);
    fin(1'b0, 1'b0);
    alloc(32'h540);
    chk("after_pop_ready", 32'(alloc_ready), 1);
    chk("after_pop_count", 32'(count), 7);
    chk("after_pop_tag", 32'(alloc_tag), 0);
    fin(1'b1, tk(32'h540));
    mpc[0] = 32'h540;
    mh = 1; nt = 1;
    for (int k = 0; k < 20; k++) begin
      resolve(3'(mh), tk(mpc[mh]), 1'b0);
      fin(1'b0, 1'b0);
      idle(1'b1);
      chk("wrap_pop_uv", 32'(upd_valid), 1);
      fin(1'b0, 1'b0);
      mh = (mh + 1) % 8;
      pc = 32'h1000 + 32'(4 * k);
      alloc(pc);
      chk("wrap_tag", 32'(alloc_tag), 32'(nt));
      fin(1'b1, tk(pc));
      mpc[nt] = pc;
      nt = (nt + 1) % 8;
    end

    // Asynchronous reset with a resolved head pending: everything drops without a clock edge.
    resolve(3'(mh), tk(mpc[mh]), 1'b0);
    fin(1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_uv", 32'(upd_valid), 1);
    chk("pre_rst_count", 32'(count), 8);
    do_reset();
    idle(1'b1);
    chk("post_rst_uv", 32'(upd_valid), 0);
    chk("post_rst_count", 32'(count), 0);
    fin(1'b0, 1'b0);

    // Flush with a resolved head, a same-cycle alloc and a CDB to a younger slot.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc = 32'h600 + 32'(4 * i);
      alloc(pc);
      fin(1'b1, tk(pc));
    end
    resolve(3'd0, tk(32'h600), 1'b0);
    fin(1'b0, 1'b0);
    resolve(3'd2, 1'b1, 1'b0);
    fin(1'b0, 1'b0);
    drv(1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 3'd3, 32'h1, 1'b0, 1'b1);
    chk("flush_uv", 32'(upd_valid), 1);
    chk("flush_pc", upd_pc, 32'h600);
    fin(1'b0, 1'b0);
    idle(1'b0);
    chk("flush_count", 32'(count), 1);
    chk("flush_tag", 32'(alloc_tag), 1);
    fin(1'b0, 1'b0);
    resolve(3'd2, 1'b1, 1'b0);
    fin(1'b0, 1'b0);
    alloc(32'h704);
    chk("flush_next_tag", 32'(alloc_tag), 1);
    fin(1'b1, tk(32'h704));
    idle(1'b1);
    chk("flush_head_pop", 32'(upd_valid), 1);
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("flush_wait_uv", 32'(upd_valid), 0);
    chk("flush_wait_count", 32'(count), 1);
    chk("flush_wait_tag", 32'(alloc_tag), 2);
    fin(1'b0, 1'b0);
    resolve(3'd1, tk(32'h704), 1'b0);
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("flush_704_uv", 32'(upd_valid), 1);
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("flushed_slot_ignored", 32'(upd_valid), 0);
    chk("flushed_slot_count", 32'(count), 0);
    fin(1'b0, 1'b0);

    // Flush coinciding with a pop of the head.
    alloc(32'h720);
    fin(1'b1, tk(32'h720));
    alloc(32'h724);
    fin(1'b1, tk(32'h724));
    resolve(3'd2, tk(32'h720), 1'b0);
    fin(1'b0, 1'b0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h1, 1'b1, 1'b1);
    chk("flushpop_uv", 32'(upd_valid), 1);
    chk("flushpop_pc", upd_pc, 32'h720);
    fin(1'b0, 1'b0);
    idle(1'b0);
    chk("flushpop_count", 32'(count), 0);
    chk("flushpop_tag", 32'(alloc_tag), 3);
    chk("flushpop_uv_after", 32'(upd_valid), 0);
    fin(1'b0, 1'b0);
    alloc(32'h730);
    chk("flushpop_alloc_tag", 32'(alloc_tag), 3);
    fin(1'b1, tk(32'h730));
    idle(1'b1);
    chk("flushpop_new_pending", 32'(upd_valid), 0);
    chk("flushpop_new_count", 32'(count), 1);
    fin(1'b0, 1'b0);
    resolve(3'd3, tk(32'h730), 1'b0);
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("flushpop_730_uv", 32'(upd_valid), 1);
    fin(1'b0, 1'b0);

    // Resolve-to-update latency on a pending head.
    do_reset();
    alloc(32'h800);
    fin(1'b1, 1'b1);
    resolve(3'd0, 1'b1, 1'b1);
    chk("byp_same_uv", 32'(upd_valid), 32'(BYP));
    chk("byp_same_taken", 32'(upd_taken), 32'(BYP));
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("byp_next_uv", 32'(upd_valid), 32'(!BYP));
    chk("byp_next_count", 32'(count), 32'(!BYP));
    fin(1'b0, 1'b0);
    idle(1'b1);
    chk("byp_final_count", 32'(count), 0);
    fin(1'b0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
